// File: rtl/cond_flag_unit.sv
// rtl/cond_flag_unit.sv - Execute-stage NZCV flags register, condition gating and E/M pipeline register (optional COND_STATS_EN annul counter)
module cond_flag_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallE,
   input  logic        FlushE,
   input  logic        CondExE,
   input  logic [1:0]  FlagWriteE,
   input  logic [3:0]  ALUFlagsE,
   input  logic        RegWriteE,
   input  logic        MemWriteE,
   input  logic        MemtoRegE,
   input  logic        PCSrcE,
   input  logic        BranchE,
   input  logic [3:0]  WA3E,
   input  logic [31:0] ALUResultE,
   input  logic [31:0] WriteDataE,
   output logic [3:0]  Flags,
   output logic        PCRedirectE,
   output logic        RegWriteM,
   output logic        MemWriteM,
   output logic        MemtoRegM,
   output logic        PCSrcM,
   output logic [3:0]  WA3M,
   output logic [31:0] ALUResultM,
   output logic [31:0] WriteDataM
`ifdef COND_STATS_EN
   ,
   output logic [15:0] AnnulCnt
`endif
);

   // An instruction survives Execute only if its condition passed and it is not being flushed
   logic live;
   logic reg_write_g;
   logic mem_write_g;
   logic mem_to_reg_g;
   logic pc_src_g;
   logic write_nz;
   logic write_cv;

   // Gate every architecturally visible side effect by the surviving condition
   always_comb begin
      live         = CondExE & ~FlushE;
      reg_write_g  = RegWriteE & live;
      mem_write_g  = MemWriteE & live;
      mem_to_reg_g = MemtoRegE & live;
      pc_src_g     = PCSrcE & live;
      write_nz     = FlagWriteE[1] & live & ~StallE;
      write_cv     = FlagWriteE[0] & live & ~StallE;
      PCRedirectE  = (PCSrcE | BranchE) & live;
   end

   // NZCV register; N,Z and C,V pairs load independently so CMP-style partial updates preserve the rest
   always_ff @(posedge clk) begin
      if (rst) begin
         Flags <= 4'b0000;
      end else begin
         if (write_nz) Flags[3:2] <= ALUFlagsE[3:2];
         if (write_cv) Flags[1:0] <= ALUFlagsE[1:0];
      end
   end

   // Execute/Memory boundary: reset beats stall, stall beats flush, flush inserts a control bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         MemtoRegM  <= 1'b0;
         PCSrcM     <= 1'b0;
         WA3M       <= 4'd0;
         ALUResultM <= 32'd0;
         WriteDataM <= 32'd0;
      end else if (!StallE) begin
         if (FlushE) begin
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
            MemtoRegM <= 1'b0;
            PCSrcM    <= 1'b0;
         end else begin
            RegWriteM <= reg_write_g;
            MemWriteM <= mem_write_g;
            MemtoRegM <= mem_to_reg_g;
            PCSrcM    <= pc_src_g;
         end
         // Data travels regardless of flush; the cleared controls make it inert downstream
         WA3M       <= WA3E;
         ALUResultM <= ALUResultE;
         WriteDataM <= WriteDataE;
      end
   end

`ifdef COND_STATS_EN
   // An annul is a condition-failed instruction that would otherwise have had a visible effect
   logic annul_event;

   // Classify the instruction in Execute as an annulled one
   always_comb begin
      annul_event = ~StallE & ~FlushE & ~CondExE &
                    (RegWriteE | MemWriteE | PCSrcE | BranchE | (|FlagWriteE));
   end

   // Saturating count of annulled instructions
   always_ff @(posedge clk) begin
      if (rst) begin
         AnnulCnt <= 16'd0;
      end else if (annul_event && (AnnulCnt != 16'hFFFF)) begin
         AnnulCnt <= AnnulCnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb/tb_cond_flag_unit.sv - Self-checking bench for cond_flag_unit (covers COND_STATS_EN when defined)
module tb_cond_flag_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        StallE, FlushE, CondExE;
   logic [1:0]  FlagWriteE;
   logic [3:0]  ALUFlagsE;
   logic        RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchE;
   logic [3:0]  WA3E;
   logic [31:0] ALUResultE, WriteDataE;
   logic [3:0]  Flags;
   logic        PCRedirectE;
   logic        RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
   logic [3:0]  WA3M;
   logic [31:0] ALUResultM, WriteDataM;
`ifdef COND_STATS_EN
   logic [15:0] AnnulCnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [3:0]  e_flags;
   logic        e_rw, e_mw, e_m2r, e_pcs;
   logic [3:0]  e_wa;
   logic [31:0] e_res, e_wd;
   bit          data_known;
   int unsigned e_cnt;

   always #5 clk = ~clk;

   cond_flag_unit dut (
      .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .CondExE(CondExE),
      .FlagWriteE(FlagWriteE), .ALUFlagsE(ALUFlagsE), .RegWriteE(RegWriteE),
      .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE), .PCSrcE(PCSrcE), .BranchE(BranchE),
      .WA3E(WA3E), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
      .Flags(Flags), .PCRedirectE(PCRedirectE), .RegWriteM(RegWriteM),
      .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .PCSrcM(PCSrcM), .WA3M(WA3M),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM)
`ifdef COND_STATS_EN
      , .AnnulCnt(AnnulCnt)
`endif
   );

   task automatic clear_inputs();
      rst = 0; StallE = 0; FlushE = 0; CondExE = 0; FlagWriteE = 0; ALUFlagsE = 0;
      RegWriteE = 0; MemWriteE = 0; MemtoRegE = 0; PCSrcE = 0; BranchE = 0;
      WA3E = 0; ALUResultE = 0; WriteDataE = 0;
   endtask

   // One clock edge; the model applies the architectural rules to the inputs present at the edge
   task automatic tick();
      bit pass;
      bit annul;
      @(posedge clk);
      if (rst) begin
         e_flags = 0; e_rw = 0; e_mw = 0; e_m2r = 0; e_pcs = 0;
         e_wa = 0; e_res = 0; e_wd = 0; data_known = 1; e_cnt = 0;
      end else begin
         pass  = CondExE && !FlushE;
         annul = !StallE && !FlushE && !CondExE &&
                 (RegWriteE || MemWriteE || PCSrcE || BranchE || FlagWriteE != 0);
         if (annul && e_cnt < 65535) e_cnt = e_cnt + 1;
         if (!StallE) begin
            if (pass && FlagWriteE[1]) e_flags[3:2] = ALUFlagsE[3:2];
            if (pass && FlagWriteE[0]) e_flags[1:0] = ALUFlagsE[1:0];
            if (FlushE) begin
               e_rw = 0; e_mw = 0; e_m2r = 0; e_pcs = 0; data_known = 0;
            end else begin
               e_rw  = RegWriteE && CondExE;
               e_mw  = MemWriteE && CondExE;
               e_m2r = MemtoRegE && CondExE;
               e_pcs = PCSrcE && CondExE;
               e_wa = WA3E; e_res = ALUResultE; e_wd = WriteDataE; data_known = 1;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1; PCSrcE = 1; CondExE = 1; StallE = 1; FlagWriteE = 2'b11; ALUFlagsE = 4'hF;
      tick();
      n_checks++;
      if ({Flags, RegWriteM, MemWriteM, MemtoRegM, PCSrcM, WA3M} !== 12'h000) begin
         n_fail++; $display("FAIL reset_ctrl got %h want 000", {Flags, RegWriteM, MemWriteM, MemtoRegM, PCSrcM, WA3M});
      end
      n_checks++;
      if ({ALUResultM, WriteDataM} !== 64'd0) begin
         n_fail++; $display("FAIL reset_data got %h want 0", {ALUResultM, WriteDataM});
      end
      n_checks++;
      if (PCRedirectE !== 1'b1) begin
         n_fail++; $display("FAIL reset_redirect got %b want 1", PCRedirectE);
      end
`ifdef COND_STATS_EN
      n_checks++;
      if (AnnulCnt !== 16'd0) begin
         n_fail++; $display("FAIL reset_cnt got %h want 0", AnnulCnt);
      end
`endif
      clear_inputs();
   endtask

   task automatic test_adds();
      do_reset();
      CondExE = 1; ALUFlagsE = 4'b0110; FlagWriteE = 2'b11; RegWriteE = 1; WA3E = 4'd3;
      ALUResultE = 32'hCAFE_0001;
      n_checks++;
      if (Flags !== 4'b0000) begin
         n_fail++; $display("FAIL adds_before got %b want 0000", Flags);
      end
      tick();
      n_checks++;
      if ({Flags, RegWriteM} !== 5'b0110_1) begin
         n_fail++; $display("FAIL adds_flags got %b/%b want 0110/1", Flags, RegWriteM);
      end
      n_checks++;
      if (ALUResultM !== 32'hCAFE_0001 || WA3M !== 4'd3) begin
         n_fail++; $display("FAIL adds_data got %h/%0d want cafe0001/3", ALUResultM, WA3M);
      end
      clear_inputs();
   endtask

   task automatic test_bne_annul();
      do_reset();
      CondExE = 1; FlagWriteE = 2'b11; ALUFlagsE = 4'b0100;
      tick();
      clear_inputs();
      CondExE = 0; BranchE = 1;
      #1;
      n_checks++;
      if (PCRedirectE !== 1'b0) begin
         n_fail++; $display("FAIL bne_redirect got %b want 0", PCRedirectE);
      end
`ifdef COND_STATS_EN
      n_checks++;
      if (AnnulCnt !== 16'd0) begin
         n_fail++; $display("FAIL bne_cnt_before got %h want 0", AnnulCnt);
      end
`endif
      tick();
      n_checks++;
      if ({Flags, PCSrcM} !== 5'b0100_0) begin
         n_fail++; $display("FAIL bne_state got %b/%b want 0100/0", Flags, PCSrcM);
      end
`ifdef COND_STATS_EN
      n_checks++;
      if (AnnulCnt !== 16'd1) begin
         n_fail++; $display("FAIL bne_cnt_after got %h want 1", AnnulCnt);
      end
`endif
      // The same branch taken redirects combinationally
      CondExE = 1;
      #1;
      n_checks++;
      if (PCRedirectE !== 1'b1) begin
         n_fail++; $display("FAIL beq_redirect got %b want 1", PCRedirectE);
      end
      clear_inputs();
   endtask

   task automatic test_cmp_partial();
      do_reset();
      CondExE = 1; FlagWriteE = 2'b11; ALUFlagsE = 4'b0001;
      tick();
      FlagWriteE = 2'b10; ALUFlagsE = 4'b1011;
      tick();
      n_checks++;
      if (Flags !== 4'b1001) begin
         n_fail++; $display("FAIL cmp_nz_only got %b want 1001", Flags);
      end
      FlagWriteE = 2'b01; ALUFlagsE = 4'b0110;
      tick();
      n_checks++;
      if (Flags !== 4'b1010) begin
         n_fail++; $display("FAIL cmp_cv_only got %b want 1010", Flags);
      end
      clear_inputs();
   endtask

   task automatic test_stall();
      do_reset();
      CondExE = 1; RegWriteE = 1; WA3E = 4'd5; ALUResultE = 32'h1111; WriteDataE = 32'h2222;
      FlagWriteE = 2'b11; ALUFlagsE = 4'b0010;
      tick();
      RegWriteE = 0; MemWriteE = 1; WA3E = 4'd9; ALUResultE = 32'h3333; WriteDataE = 32'h4444;
      ALUFlagsE = 4'b1101; StallE = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if ({Flags, RegWriteM, MemWriteM, WA3M} !== 10'b0010_1_0_0101 ||
             ALUResultM !== 32'h1111 || WriteDataM !== 32'h2222) begin
            n_fail++; $display("FAIL stall_hold%0d got %b %b %b %0d %h %h want 0010 1 0 5 1111 2222",
                               i, Flags, RegWriteM, MemWriteM, WA3M, ALUResultM, WriteDataM);
         end
      end
      StallE = 0;
      tick();
      n_checks++;
      if ({Flags, MemWriteM, RegWriteM, WA3M} !== 10'b1101_1_0_1001 || WriteDataM !== 32'h4444) begin
         n_fail++; $display("FAIL stall_release got %b %b %b %0d %h want 1101 1 0 9 4444",
                            Flags, MemWriteM, RegWriteM, WA3M, WriteDataM);
      end
      MemWriteE = 0; FlagWriteE = 2'b00; ALUFlagsE = 4'b0000;
      tick();
      n_checks++;
      if (Flags !== 4'b1101) begin
         n_fail++; $display("FAIL stall_once got %b want 1101", Flags);
      end
      clear_inputs();
   endtask

   task automatic test_flush();
      do_reset();
      CondExE = 1; FlagWriteE = 2'b11; ALUFlagsE = 4'b1000;
      tick();
      MemtoRegE = 1; RegWriteE = 1; PCSrcE = 1; FlagWriteE = 2'b11; ALUFlagsE = 4'b0111; FlushE = 1;
      #1;
      n_checks++;
      if (PCRedirectE !== 1'b0) begin
         n_fail++; $display("FAIL flush_redirect got %b want 0", PCRedirectE);
      end
      tick();
      n_checks++;
      if ({Flags, RegWriteM, MemtoRegM, PCSrcM} !== 7'b1000_000) begin
         n_fail++; $display("FAIL flush_bubble got %b %b %b %b want 1000 0 0 0", Flags, RegWriteM, MemtoRegM, PCSrcM);
      end
      // Load a real instruction, then flush+stall together must hold it
      FlushE = 0; PCSrcE = 0; FlagWriteE = 0; WA3E = 4'd7; ALUResultE = 32'hABCD;
      tick();
      FlushE = 1; StallE = 1; FlagWriteE = 2'b11; ALUFlagsE = 4'b0101; WA3E = 4'd1; RegWriteE = 0;
      tick();
      n_checks++;
      if ({Flags, RegWriteM, MemtoRegM, WA3M} !== 10'b1000_1_1_0111 || ALUResultM !== 32'hABCD) begin
         n_fail++; $display("FAIL flush_stall_hold got %b %b %b %0d %h want 1000 1 1 7 abcd",
                            Flags, RegWriteM, MemtoRegM, WA3M, ALUResultM);
      end
      // Reset on the same edge overrides both
      rst = 1;
      tick();
      n_checks++;
      if ({Flags, RegWriteM, MemtoRegM, WA3M} !== 10'd0 || ALUResultM !== 32'd0) begin
         n_fail++; $display("FAIL rst_override got %b %b %b %0d %h want 0", Flags, RegWriteM, MemtoRegM, WA3M, ALUResultM);
      end
      clear_inputs();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst        = ($urandom_range(0, 39) == 0);
         StallE     = ($urandom_range(0, 4) == 0);
         FlushE     = ($urandom_range(0, 4) == 0);
         CondExE    = $urandom_range(0, 1);
         FlagWriteE = $urandom_range(0, 3);
         ALUFlagsE  = $urandom_range(0, 15);
         RegWriteE  = $urandom_range(0, 1);
         MemWriteE  = $urandom_range(0, 1);
         MemtoRegE  = $urandom_range(0, 1);
         PCSrcE     = $urandom_range(0, 1);
         BranchE    = $urandom_range(0, 1);
         WA3E       = $urandom_range(0, 15);
         ALUResultE = $urandom;
         WriteDataE = $urandom;
         #1;
         n_checks++;
         if (PCRedirectE !== ((PCSrcE || BranchE) && CondExE && !FlushE)) begin
            n_fail++; $display("FAIL rand_redirect cycle %0d got %b", i, PCRedirectE);
         end
         tick();
         n_checks++;
         if ({Flags, RegWriteM, MemWriteM, MemtoRegM, PCSrcM} !== {e_flags, e_rw, e_mw, e_m2r, e_pcs}) begin
            n_fail++; $display("FAIL rand_ctrl cycle %0d got %b want %b", i,
                               {Flags, RegWriteM, MemWriteM, MemtoRegM, PCSrcM}, {e_flags, e_rw, e_mw, e_m2r, e_pcs});
         end
         if (data_known) begin
            n_checks++;
            if ({WA3M, ALUResultM, WriteDataM} !== {e_wa, e_res, e_wd}) begin
               n_fail++; $display("FAIL rand_data cycle %0d got %h want %h", i,
                                  {WA3M, ALUResultM, WriteDataM}, {e_wa, e_res, e_wd});
            end
         end
`ifdef COND_STATS_EN
         n_checks++;
         if (AnnulCnt !== e_cnt[15:0]) begin
            n_fail++; $display("FAIL rand_cnt cycle %0d got %h want %h", i, AnnulCnt, e_cnt[15:0]);
         end
`endif
      end
      clear_inputs();
   endtask

`ifdef COND_STATS_EN
   task automatic test_saturate();
      do_reset();
      CondExE = 1; FlagWriteE = 2'b11; ALUFlagsE = 4'b1010;
      tick();
      clear_inputs();
      RegWriteE = 1;
      repeat (65534) tick();
      n_checks++;
      if (AnnulCnt !== 16'hFFFE) begin
         n_fail++; $display("FAIL sat_fffe got %h want fffe", AnnulCnt);
      end
      for (int i = 0; i < 3; i++) begin
         FlagWriteE = 2'(i + 1); RegWriteE = 0; BranchE = (i == 2);
         tick();
      end
      n_checks++;
      if (AnnulCnt !== 16'hFFFF || Flags !== 4'b1010) begin
         n_fail++; $display("FAIL sat_ffff got %h/%b want ffff/1010", AnnulCnt, Flags);
      end
      rst = 1;
      tick();
      n_checks++;
      if (AnnulCnt !== 16'd0 || Flags !== 4'b0000) begin
         n_fail++; $display("FAIL sat_rst got %h/%b want 0/0000", AnnulCnt, Flags);
      end
      clear_inputs();
   endtask
`endif

   initial begin
      clear_inputs();
      test_reset();
      test_adds();
      test_bne_annul();
      test_cmp_partial();
      test_stall();
      test_flush();
      test_random();
`ifdef COND_STATS_EN
      test_saturate();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
